// File: rtl/jpeg_line_fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// jpeg_line_fifo_rd_ctrl
//
// Read-side sequencer for the encoder's asynchronous pixel line FIFO. It runs
// entirely in the FIFO read clock domain. After a frame-start pulse it waits
// until the FIFO holds at least one full burst, reads the burst into a
// 2-entry output buffer and streams the pixels downstream on a valid/ready
// interface tagged with start/end of line and frame markers.
//
// Ports
//   i_rd_clk               read clock (shared with the FIFO read port)
//   i_rd_rst_n             asynchronous active-low reset
//   i_frame_start          one-cycle pulse arming one frame (ignored when busy)
//   o_fifo_rd_en           FIFO read enable
//   i_fifo_rd_data         FIFO read data, valid the cycle after o_fifo_rd_en
//   i_fifo_rd_empty        FIFO empty flag
//   i_fifo_rd_water_level  FIFO read-side fill count
//   o_m_data / o_m_valid / i_m_ready   downstream pixel stream
//   o_m_sol / o_m_eol      first / last pixel of a line
//   o_m_sof / o_m_eof      first / last pixel of the frame
//   o_busy                 a frame is in progress
//   o_frame_done           one-cycle pulse after the last beat is accepted
//   o_underflow_err        sticky: a read was wanted while the FIFO was empty
// ---------------------------------------------------------------------------
module jpeg_line_fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 24,
  parameter int LVL_WIDTH  = 13,
  parameter int BURST_LEN  = 8,
  parameter int H_PIXELS   = 640,
  parameter int V_LINES    = 480
) (
  input  logic                  i_rd_clk,
  input  logic                  i_rd_rst_n,
  input  logic                  i_frame_start,
  output logic                  o_fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
  input  logic                  i_fifo_rd_empty,
  input  logic [LVL_WIDTH-1:0]  i_fifo_rd_water_level,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic                  o_m_sol,
  output logic                  o_m_eol,
  output logic                  o_m_sof,
  output logic                  o_m_eof,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_underflow_err
);

  localparam int TOTAL = H_PIXELS * V_LINES;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int BC_W  = $clog2(BURST_LEN + 1);
  localparam int X_W   = $clog2(H_PIXELS + 1);
  localparam int Y_W   = $clog2(V_LINES + 1);

  localparam logic [CNT_W-1:0]     LP_TOTAL      = CNT_W'(TOTAL);
  localparam logic [BC_W-1:0]      LP_BURST_LAST = BC_W'(BURST_LEN - 1);
  localparam logic [LVL_WIDTH-1:0] LP_BURST_LVL  = LVL_WIDTH'(BURST_LEN);
  localparam logic [X_W-1:0]       LP_X_LAST     = X_W'(H_PIXELS - 1);
  localparam logic [Y_W-1:0]       LP_Y_LAST     = Y_W'(V_LINES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_LVL = 2'd1,
    S_BURST    = 2'd2,
    S_DRAIN    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                  r_inflight;
  logic                  r_frame_done;
  logic                  r_underflow;
  logic [BC_W-1:0]       r_burst_cnt;
  logic [CNT_W-1:0]      r_rd_cnt;
  logic [CNT_W-1:0]      w_rd_cnt_inc;

  logic [DATA_WIDTH-1:0] r_buf [0:1];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_occ;
  logic [1:0]            w_occ_next;

  logic [X_W-1:0]        r_x;
  logic [Y_W-1:0]        r_y;

  logic w_push;
  logic w_pop;
  logic w_room;
  logic w_rd_en;
  logic w_start;
  logic w_burst_start;
  logic w_done;
  logic w_valid;

  // The buffer is written by the read issued one cycle earlier.
  assign w_push  = r_inflight;
  assign w_valid = (r_occ != 2'd0);
  assign w_pop   = w_valid && i_m_ready;

  // occ + inflight - pop < 2, rearranged so nothing goes negative.
  assign w_room = ({1'b0, r_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

  assign w_rd_en      = (r_state == S_BURST) && !i_fifo_rd_empty && w_room;
  assign w_occ_next   = r_occ + {1'b0, w_push} - {1'b0, w_pop};
  assign w_rd_cnt_inc = r_rd_cnt + CNT_W'(1);

  // A start pulse landing in the frame_done cycle must not re-arm.
  assign w_start = (r_state == S_IDLE) && i_frame_start && !r_frame_done;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_burst_start = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_next = S_WAIT_LVL;
        end
      end
      S_WAIT_LVL: begin
        // The level only reflects completed reads, so let the last read land.
        if (!r_inflight && (i_fifo_rd_water_level >= LP_BURST_LVL)) begin
          w_state_next  = S_BURST;
          w_burst_start = 1'b1;
        end
      end
      S_BURST: begin
        if (w_rd_en && (r_burst_cnt == LP_BURST_LAST)) begin
          w_state_next = (w_rd_cnt_inc == LP_TOTAL) ? S_DRAIN : S_WAIT_LVL;
        end
      end
      S_DRAIN: begin
        // Look ahead at the buffer count so frame_done and IDLE both appear
        // in the cycle right after the final beat is taken.
        if (!r_inflight && (w_occ_next == 2'd0)) begin
          w_state_next = S_IDLE;
          w_done       = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Control state and read counters
  // -------------------------------------------------------------------------
  always_ff @(posedge i_rd_clk or negedge i_rd_rst_n) begin
    if (!i_rd_rst_n) begin
      r_state      <= S_IDLE;
      r_inflight   <= 1'b0;
      r_frame_done <= 1'b0;
      r_underflow  <= 1'b0;
      r_burst_cnt  <= '0;
      r_rd_cnt     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_inflight   <= w_rd_en;
      r_frame_done <= w_done;

      // Buffer had room for a read but the FIFO had nothing to give.
      if ((r_state == S_BURST) && i_fifo_rd_empty && w_room) begin
        r_underflow <= 1'b1;
      end

      if (w_start) begin
        r_rd_cnt <= '0;
      end else if (w_rd_en) begin
        r_rd_cnt <= w_rd_cnt_inc;
      end

      if (w_burst_start) begin
        r_burst_cnt <= '0;
      end else if (w_rd_en) begin
        r_burst_cnt <= r_burst_cnt + BC_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // 2-entry output buffer
  // -------------------------------------------------------------------------
  always_ff @(posedge i_rd_clk or negedge i_rd_rst_n) begin
    if (!i_rd_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_buf[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf[r_wr_ptr] <= i_fifo_rd_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ <= w_occ_next;
    end
  end

  // -------------------------------------------------------------------------
  // Output position counters (advance on each accepted beat)
  // -------------------------------------------------------------------------
  always_ff @(posedge i_rd_clk or negedge i_rd_rst_n) begin
    if (!i_rd_rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_start) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_pop) begin
      if (r_x == LP_X_LAST) begin
        r_x <= '0;
        r_y <= (r_y == LP_Y_LAST) ? '0 : (r_y + Y_W'(1));
      end else begin
        r_x <= r_x + X_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign o_fifo_rd_en    = w_rd_en;
  assign o_m_valid       = w_valid;
  assign o_m_data        = w_valid ? r_buf[r_rd_ptr] : '0;
  assign o_m_sol         = w_valid && (r_x == '0);
  assign o_m_eol         = w_valid && (r_x == LP_X_LAST);
  assign o_m_sof         = w_valid && (r_x == '0) && (r_y == '0);
  assign o_m_eof         = w_valid && (r_x == LP_X_LAST) && (r_y == LP_Y_LAST);
  assign o_busy          = (r_state != S_IDLE);
  assign o_frame_done    = r_frame_done;
  assign o_underflow_err = r_underflow;

endmodule

// File: tb/tb_jpeg_line_fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jpeg_line_fifo_rd_ctrl
//
// Scoreboard bench for jpeg_line_fifo_rd_ctrl with a small frame (16x2,
// burst 8). Each frame loads random pixels into a queue-based FIFO model and
// pushes the expected beat stream (pixel + markers derived from the beat
// index) into a scoreboard; a negedge monitor pops and compares every
// accepted beat and checks the stream/FIFO rules cycle by cycle.
// ---------------------------------------------------------------------------
module tb_jpeg_line_fifo_rd_ctrl;

  localparam int DW = 24;
  localparam int LW = 13;
  localparam int BL = 8;
  localparam int H  = 16;
  localparam int V  = 2;
  localparam int HV = H * V;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_empty;
  logic [LW-1:0] lvl;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_sol, m_eol, m_sof, m_eof;
  logic          busy, frame_done, underflow_err;

  always #5 clk = ~clk;

  jpeg_line_fifo_rd_ctrl #(
    .DATA_WIDTH (DW),
    .LVL_WIDTH  (LW),
    .BURST_LEN  (BL),
    .H_PIXELS   (H),
    .V_LINES    (V)
  ) dut (
    .i_rd_clk              (clk),
    .i_rd_rst_n            (rst_n),
    .i_frame_start         (frame_start),
    .o_fifo_rd_en          (fifo_rd_en),
    .i_fifo_rd_data        (fifo_rd_data),
    .i_fifo_rd_empty       (fifo_rd_empty),
    .i_fifo_rd_water_level (lvl),
    .o_m_data              (m_data),
    .o_m_valid             (m_valid),
    .i_m_ready             (m_ready),
    .o_m_sol               (m_sol),
    .o_m_eol               (m_eol),
    .o_m_sof               (m_sof),
    .o_m_eof               (m_eof),
    .o_busy                (busy),
    .o_frame_done          (frame_done),
    .o_underflow_err       (underflow_err)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sol;
    logic          eol;
    logic          sof;
    logic          eof;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] fifo_q[$];

  int fifo_cnt  = 0;
  int lvl_force = -1;
  bit force_empty = 1'b0;
  bit ready_rand  = 1'b0;
  bit rd_seen     = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rd_total = 0;
  int acc_total = 0;
  int done_cnt = 0;
  int fs_cyc = -1;
  int first_rd_cyc = -1;
  int first_valid_cyc = -1;
  int eof_cyc = -100;
  bit    prev_stall = 1'b0;
  beat_t prev_beat;

  assign fifo_rd_empty = force_empty || (fifo_cnt == 0);
  assign lvl = (lvl_force >= 0) ? LW'(lvl_force) : LW'(fifo_cnt);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // FIFO read port model: a read seen before the edge delivers data after it.
  initial forever begin
    @(posedge clk);
    #1;
    if (rd_seen && rst_n && (fifo_q.size() > 0)) begin
      fifo_rd_data = fifo_q.pop_front();
      fifo_cnt     = fifo_q.size();
    end
    rd_seen = 1'b0;
    if (ready_rand) m_ready = 1'($urandom_range(0, 1));
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    beat_t cb;
    beat_t eb;
    cyc++;
    cb = {m_data, m_sol, m_eol, m_sof, m_eof};
    rd_seen = fifo_rd_en;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (fifo_rd_empty) check("rd_en_while_empty", fifo_rd_en, 0);
      if (fifo_rd_en) begin
        check("outstanding_le_2",
              ((rd_total + 1 - acc_total - int'(m_valid && m_ready)) <= 2), 1);
        rd_total++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall) check("hold_while_stalled", {m_valid, cb}, {1'b1, prev_beat});
      if (m_valid && m_ready) begin
        acc_total++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: actual=%0h required=no beat", cb);
        end else begin
          eb = exp_q.pop_front();
          check("beat", cb, eb);
          if (eb.eof) eof_cyc = cyc;
        end
      end
      if (frame_done) begin
        done_cnt++;
        check("frame_done_latency", cyc - eof_cyc, 1);
        check("busy_at_frame_done", busy, 0);
      end
      if (frame_start && !busy) fs_cyc = cyc;
      prev_stall = m_valid && !m_ready;
      prev_beat  = cb;
    end
  end

  task automatic start_frame();
    logic [DW-1:0] px;
    for (int k = 0; k < HV; k++) begin
      px = DW'($urandom());
      fifo_q.push_back(px);
      exp_q.push_back({px, (k % H == 0), (k % H == H - 1), (k == 0), (k == HV - 1)});
    end
    fifo_cnt        = fifo_q.size();
    first_rd_cyc    = -1;
    first_valid_cyc = -1;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_in_time"}, (n < budget), 1);
    repeat (3) @(negedge clk);
    check({name, "_done_count"}, done_cnt - d0, 1);
    check({name, "_beats_left"}, exp_q.size(), 0);
    check({name, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int n;
    int base;
    int d0;
    bit any;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {fifo_rd_en, m_valid, m_data, m_sol, m_eol, m_sof, m_eof, busy, frame_done, underflow_err}, 0);
    tick();
    rst_n = 1'b1;
    tick(2);

    // Basic frame with the level held at one burst
    lvl_force = BL;
    start_frame();
    wait_done("basic", 300);
    check("basic_first_rd_latency", first_rd_cyc - fs_cyc, 2);
    check("basic_first_valid_latency", first_valid_cyc - fs_cyc, 4);
    check("basic_no_underflow", underflow_err, 0);

    // Level gating
    tick();
    lvl_force = BL - 1;
    start_frame();
    any = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (fifo_rd_en) any = 1'b1;
    end
    check("lvl_no_rd_below_burst", any, 0);
    check("lvl_busy_while_waiting", busy, 1);
    tick();
    lvl_force = BL;
    @(negedge clk);
    check("lvl_no_rd_same_cycle", fifo_rd_en, 0);
    @(negedge clk);
    check("lvl_rd_one_cycle_later", fifo_rd_en, 1);
    wait_done("level", 300);
    tick();
    lvl_force = -1;

    // Random backpressure
    ready_rand = 1'b1;
    start_frame();
    wait_done("backpressure", 3000);
    tick();
    ready_rand = 1'b0;
    tick();
    m_ready = 1'b1;

    // FIFO empty mid-burst
    check("pre_empty_no_underflow", underflow_err, 0);
    base = rd_total;
    start_frame();
    n = 0;
    while ((rd_total - base) < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("empty_reached_burst", (n < 500), 1);
    tick();
    force_empty = 1'b1;
    tick(2);
    @(negedge clk);
    check("underflow_set", underflow_err, 1);
    tick();
    force_empty = 1'b0;
    wait_done("empty", 500);
    check("underflow_sticky", underflow_err, 1);

    // Reset mid-frame at beat 10
    tick();
    base = acc_total;
    start_frame();
    n = 0;
    while ((acc_total - base) < 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reset_reached_beat10", (n < 500), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs",
          {fifo_rd_en, m_valid, m_data, m_sol, m_eol, m_sof, m_eof, busy, frame_done, underflow_err}, 0);
    exp_q.delete();
    fifo_q.delete();
    fifo_cnt  = 0;
    rd_seen   = 1'b0;
    rd_total  = 0;
    acc_total = 0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("busy_after_reset_release", busy, 0);
    start_frame();
    wait_done("after_reset", 500);

    // Spurious starts while busy and in the frame_done cycle
    d0 = done_cnt;
    start_frame();
    tick(5);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick(10);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n = 0;
    while (!(m_valid && m_ready && m_eof) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("spurious_reached_eof", (n < 500), 1);
    @(posedge clk);
    #2;
    frame_start = 1'b1;
    check("spurious_done_cycle", frame_done, 1);
    tick();
    frame_start = 1'b0;
    repeat (30) @(negedge clk);
    check("spurious_done_count", done_cnt - d0, 1);
    check("spurious_not_rearmed", busy, 0);
    check("spurious_beats_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jpeg_line_fifo_rd_ctrl.md
# jpeg_line_fifo_rd_ctrl

Read-side sequencer for the JPEG encoder's 24-bit asynchronous line FIFO, in the FIFO's read clock domain. Arms on a frame-start pulse and waits until the FIFO read water level covers a full burst. Then issues bursts of `fifo_rd_en`, buffers the returned pixels in a 2-entry output buffer, and presents them downstream on a valid/ready stream tagged with line and frame markers.

## Interface
- `DATA_WIDTH`, 24, pixel width; matches the FIFO read data width.
- `LVL_WIDTH`, 13, width of the FIFO read water level (depth width + 1).
- `BURST_LEN`, 8, pixels per read burst; must divide `H_PIXELS`.
- `H_PIXELS`, 640, pixels per line.
- `V_LINES`, 480, lines per frame.
- `rd_clk`, in, 1, read clock, shared with the FIFO read port.
- `rd_rst_n`, in, 1, reset; **asynchronous, active-low**.
- `frame_start`, in, 1, one-cycle pulse that arms one frame; ignored while `busy`=1.
- `fifo_rd_en`, out, 1, FIFO read enable.
- `fifo_rd_data`, in, DATA_WIDTH, FIFO read data; valid the cycle after `fifo_rd_en`.
- `fifo_rd_empty`, in, 1, FIFO empty flag.
- `fifo_rd_water_level`, in, LVL_WIDTH, FIFO read-side fill count.
- `m_data`, out, DATA_WIDTH, pixel to the encoder.
- `m_valid`, out, 1, `m_data` is valid.
- `m_ready`, in, 1, downstream accepts a beat.
- `m_sol`, out, 1, beat is the first pixel of a line.
- `m_eol`, out, 1, beat is the last pixel of a line.
- `m_sof`, out, 1, beat is the first pixel of the frame.
- `m_eof`, out, 1, beat is the last pixel of the frame.
- `busy`, out, 1, a frame is in progress.
- `frame_done`, out, 1, one-cycle pulse after the last beat is accepted.
- `underflow_err`, out, 1, sticky flag: a read was wanted while the FIFO was empty during a burst.

## Operation
- Reset value of every output is 0. Reset clears all state, counters, the buffer and `underflow_err`.
- **States:** IDLE, WAIT_LVL, BURST, DRAIN.
- **IDLE:** on `frame_start`, go to WAIT_LVL and clear the read counter `rd_cnt` (0..H_PIXELS*V_LINES).
- **WAIT_LVL:** if no read is in flight and `fifo_rd_water_level >= BURST_LEN`, go to BURST with `burst_cnt`=0.
- **BURST:**
  - Issue condition: `fifo_rd_en = !fifo_rd_empty && (occ + inflight - pop) < 2`.
    - `occ` is the buffer count (0..2).
    - `inflight` is the registered `fifo_rd_en` of the previous cycle.
    - `pop` is `m_valid && m_ready`.
  - Each issued read increments `burst_cnt` and `rd_cnt`.
  - When `burst_cnt` reaches BURST_LEN: go to DRAIN if `rd_cnt == H_PIXELS*V_LINES`, else go to WAIT_LVL.
- **Empty FIFO in BURST:** if `fifo_rd_empty`=1 while the buffer has room, no read is issued, the burst stalls, and `underflow_err` is set.
- **DRAIN:** when `occ`=0, no read is in flight and no beat is pending, pulse `frame_done` and go to IDLE.
- **Output buffer:** 2-entry FIFO.
  - Write when `inflight`=1; read on `pop`; simultaneous write and read is supported.
  - It never overflows by construction.
- **Output counters:** `x` counts 0..H_PIXELS-1 and `y` counts 0..V_LINES-1; both advance on `pop`, and `x` wraps to 0 with `y`+1.
  - `m_sol` = (`x`==0); `m_eol` = (`x`==H_PIXELS-1).
  - `m_sof` = (`x`==0 && `y`==0); `m_eof` = (`x`==H_PIXELS-1 && `y`==V_LINES-1).
  - All four markers are qualified by `m_valid`.
- `busy` = (state != IDLE).
- `m_data`/`m_valid` follow AXI-style rules: once `m_valid` is asserted, `m_data` and the markers hold until `pop`.
- **Width rule:** `rd_cnt` is sized as clog2(H_PIXELS*V_LINES+1) bits. The water-level comparison is unsigned at LVL_WIDTH.

## Timing
- `frame_start` sampled at edge N: WAIT_LVL in cycle N+1.
- With the level satisfied at N+1: BURST and first `fifo_rd_en` in cycle N+2.
- Data is captured at the end of N+3; first `m_valid` in cycle N+4.
- Sustained throughput is 1 pixel/cycle within a burst when `m_ready`=1.
- Inter-burst gap is at least 2 cycles: the in-flight read must clear, then the level is re-checked.
- `m_ready`=0 for two or more cycles: at most 2 beats are buffered and `fifo_rd_en` deasserts within 1 cycle.
- Last beat accepted at edge M: `frame_done` is high in cycle M+1, with state IDLE and `busy`=0 in the same cycle.
- `frame_start` coincident with the `frame_done` cycle is ignored.
- Reset asserted mid-frame: all outputs are 0 immediately (asynchronous). After release the block waits in IDLE; FIFO contents are not flushed by this block.

## Test plan
- **Basic frame** (H=16, V=2, BURST=8, level held at 8, `m_ready`=1):
  - Required: 32 beats in order.
  - `m_sof` on beat 0; `m_eol` on beats 15 and 31; `m_sol` on beats 0 and 16; `m_eof` on beat 31.
  - `frame_done` one cycle after beat 31.
- **Level gating:** level=7 for 20 cycles, then 8.
  - Required: no `fifo_rd_en` while the level is 7; first `fifo_rd_en` 1 cycle after the level reaches 8.
- **Backpressure:** `m_ready` toggles 0/1 pseudo-randomly.
  - Required: no data lost or duplicated; data and markers stable while stalled.
  - At most 2 reads outstanding beyond accepted beats.
- **Empty during burst:** `fifo_rd_empty` forced to 1 for 3 cycles mid-burst.
  - Required: no `fifo_rd_en` while empty; `underflow_err`=1 and sticky; burst resumes and the frame completes correctly.
- **Reset mid-frame:** `rd_rst_n` pulsed low at beat 10.
  - Required: all outputs 0 at once; `busy`=0 after release; a new `frame_start` yields a fresh frame with `m_sof` on the first beat.
- **Spurious start:** `frame_start` pulsed while `busy`=1.
  - Required: ignored; exactly H*V beats and exactly one `frame_done`.
